// File: rtl/dac_driver.sv
// LUT-driven DAC pulse generator: GPIO-programmed 16-bit code table, one value in -> pulse_len code words then gap_len zero words.
// First code word is presented two cycles after acceptance; m_axis_tready low freezes tdata and all counters, val_ready only in IDLE.
module dac_driver #(
    parameter int num_bits    = 8,
    parameter int lut_idx_reg = 5,
    parameter int lut_lo_reg  = 6,
    parameter int lut_hi_reg  = 7,
    parameter int pulse_reg   = 8,
    parameter int ctrl_reg    = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         gpio_in,
    input  logic [num_bits-1:0] val_in,
    input  logic                val_valid,
    output logic                val_ready,
    output logic [127:0]        m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        PULSE  = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [num_bits-1:0] LP_IDX_ONE = num_bits'(1);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]         r_gpio_s1;
    logic [31:0]         r_gpio_s2;
    logic                r_wclk_d;

    logic [num_bits-1:0] r_lut_idx;
    logic [7:0]          r_lo;
    logic                r_enable;
    logic [3:0]          r_pulse_len;
    logic [3:0]          r_gap_len;

    logic [num_bits-1:0] r_val;
    logic [15:0]         r_lut [2**num_bits];
    logic [15:0]         r_code;
    logic [3:0]          r_cnt;
    logic [3:0]          r_gap;
    logic                r_busy;
    logic                r_tvalid;

    logic                w_wr;
    logic [15:0]         w_addr;
    logic [7:0]          w_data;
    logic                w_wr_hi;
    logic                w_accept;
    logic                w_xfer;
    logic                w_unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gpio_s1 <= '0;
            r_gpio_s2 <= '0;
            r_wclk_d  <= 1'b0;
        end else begin
            r_gpio_s1 <= gpio_in;
            r_gpio_s2 <= r_gpio_s1;
            r_wclk_d  <= r_gpio_s2[24];
        end
    end

    assign w_wr          = r_gpio_s2[24] & ~r_wclk_d;
    assign w_addr        = r_gpio_s2[15:0];
    assign w_data        = r_gpio_s2[23:16];
    assign w_wr_hi       = w_wr && (w_addr == 16'(lut_hi_reg));
    assign w_unused_bits = ^r_gpio_s2[31:25];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lut_idx   <= '0;
            r_lo        <= '0;
            r_enable    <= 1'b0;
            r_pulse_len <= 4'd1;
            r_gap_len   <= 4'd0;
        end else if (w_wr) begin
            if (w_addr == 16'(lut_idx_reg)) r_lut_idx <= num_bits'(w_data);
            if (w_addr == 16'(lut_lo_reg))  r_lo      <= w_data;
            if (w_wr_hi)                    r_lut_idx <= r_lut_idx + LP_IDX_ONE;
            if (w_addr == 16'(pulse_reg)) begin
                r_pulse_len <= w_data[3:0];
                r_gap_len   <= w_data[7:4];
            end
            if (w_addr == 16'(ctrl_reg))    r_enable  <= w_data[0];
        end
    end

    // Table RAM: the LOOKUP read sees the pre-write contents on a same-entry collision.
    always_ff @(posedge clk) begin
        if (w_wr_hi) r_lut[r_lut_idx] <= {w_data, r_lo};
        if (r_state == LOOKUP) r_code <= r_lut[r_val];
    end

    assign w_accept = (r_state == IDLE) && r_enable && val_valid;
    assign w_xfer   = r_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        val_ready    = 1'b0;
        m_axis_tdata = '0;
        case (r_state)
            IDLE: begin
                val_ready = r_enable;
                if (w_accept) w_state_nxt = LOOKUP;
            end
            LOOKUP: w_state_nxt = PULSE;
            PULSE: begin
                m_axis_tdata = {8{r_code}};
                if (w_xfer && (r_cnt == 4'd1)) w_state_nxt = (r_gap == 4'd0) ? IDLE : GAP;
            end
            GAP: begin
                if (w_xfer && (r_cnt == 4'd1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pulse and gap length are frozen at LOOKUP so mid-pulse reprogramming waits for the next value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_val    <= '0;
            r_cnt    <= '0;
            r_gap    <= '0;
            r_busy   <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            r_tvalid <= 1'b1;
            r_busy   <= (w_state_nxt != IDLE);
            if (w_accept) r_val <= val_in;
            case (r_state)
                LOOKUP: begin
                    r_cnt <= (r_pulse_len == 4'd0) ? 4'd1 : r_pulse_len;
                    r_gap <= r_gap_len;
                end
                PULSE: begin
                    if (w_xfer) r_cnt <= (r_cnt == 4'd1) ? r_gap : r_cnt - 4'd1;
                end
                GAP: begin
                    if (w_xfer) r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy          = r_busy;
    assign m_axis_tvalid = r_tvalid;

endmodule

// File: tb/tb_dac_driver.sv
// Directed bench for dac_driver: GPIO LUT programming, pulse/gap timing, backpressure, boundaries, enable and reset.
module tb_dac_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  gpio_in;
    logic [7:0]   val_in;
    logic         val_valid;
    logic         val_ready;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dac_driver dut (
        .clk           (clk),
        .rst           (rst),
        .gpio_in       (gpio_in),
        .val_in        (val_in),
        .val_valid     (val_valid),
        .val_ready     (val_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
    );

    function automatic logic [127:0] rep(input logic [15:0] c);
        return {8{c}};
    endfunction

    // Seven falling edges from call to return; the register write lands inside that window.
    task automatic gpio_write(input logic [15:0] a, input logic [7:0] d);
        gpio_in = {8'h00, d, a};
        repeat (2) @(negedge clk);
        gpio_in[24] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_in[24] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Returns on the falling edge of the cycle after acceptance (the LOOKUP cycle).
    task automatic send_val(input logic [7:0] v, output bit ok);
        ok        = 1'b0;
        val_in    = v;
        val_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            if (val_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        val_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst           = 1'b0;
        gpio_in       = '0;
        val_in        = '0;
        val_valid     = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        total++; if (m_axis_tdata !== '0)    begin bad++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
        total++; if (val_ready !== 1'b0)     begin bad++; $display("FAIL rst_val_ready: got %b want 0", val_ready); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL post_rst_tvalid: got %b want 1", m_axis_tvalid); end
        total++; if (val_ready !== 1'b0)     begin bad++; $display("FAIL post_rst_ready_disabled: got %b want 0", val_ready); end
    endtask

    task automatic test_lut_load;
        bit ok;
        gpio_write(16'd5, 8'h03);
        gpio_write(16'd6, 8'h34);
        gpio_write(16'd7, 8'h12);
        gpio_write(16'd6, 8'h78);
        gpio_write(16'd7, 8'h56);
        gpio_write(16'd9, 8'h01);
        send_val(8'd3, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL lut_accept3: got %b want 1", ok); end
        @(negedge clk);
        total++; if (m_axis_tdata !== rep(16'h1234)) begin bad++; $display("FAIL lut_word3: got %h want %h", m_axis_tdata, rep(16'h1234)); end
        send_val(8'd4, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL lut_accept4: got %b want 1", ok); end
        @(negedge clk);
        total++; if (m_axis_tdata !== rep(16'h5678)) begin bad++; $display("FAIL lut_word4: got %h want %h", m_axis_tdata, rep(16'h5678)); end
    endtask

    task automatic test_timing;
        bit ok;
        logic [127:0] exp;
        gpio_write(16'd8, 8'h23);
        send_val(8'd3, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL timing_accept: got %b want 1", ok); end
        total++; if (m_axis_tdata !== '0) begin bad++; $display("FAIL timing_lookup_tdata: got %h want 0", m_axis_tdata); end
        total++; if (busy !== 1'b1)       begin bad++; $display("FAIL timing_lookup_busy: got %b want 1", busy); end
        total++; if (val_ready !== 1'b0)  begin bad++; $display("FAIL timing_lookup_ready: got %b want 0", val_ready); end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            exp = (k <= 4) ? rep(16'h1234) : '0;
            total++;
            if (m_axis_tdata !== exp) begin bad++; $display("FAIL timing_tdata_N+%0d: got %h want %h", k, m_axis_tdata, exp); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL timing_gap_busy: got %b want 1", busy); end
        @(negedge clk);
        total++; if (val_ready !== 1'b1) begin bad++; $display("FAIL timing_ready_N+7: got %b want 1", val_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL timing_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int xfer = 0;
        int stall_bad = 0;
        gpio_write(16'd8, 8'h04);
        send_val(8'd4, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_accept: got %b want 1", ok); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            m_axis_tready = !(i >= 1 && i <= 5);
            if (m_axis_tready) begin
                if (m_axis_tdata === rep(16'h5678)) xfer++;
            end else if (m_axis_tdata !== rep(16'h5678)) begin
                stall_bad++;
            end
        end
        m_axis_tready = 1'b1;
        total++; if (xfer != 4)      begin bad++; $display("FAIL bp_transfers: got %0d want 4", xfer); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL bp_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_pulse_zero;
        bit ok;
        gpio_write(16'd8, 8'h00);
        send_val(8'd3, ok);
        @(negedge clk);
        total++; if (m_axis_tdata !== rep(16'h1234)) begin bad++; $display("FAIL p0_word: got %h want %h", m_axis_tdata, rep(16'h1234)); end
        @(negedge clk);
        total++; if (m_axis_tdata !== '0)  begin bad++; $display("FAIL p0_after: got %h want 0", m_axis_tdata); end
        total++; if (val_ready !== 1'b1)   begin bad++; $display("FAIL p0_ready: got %b want 1", val_ready); end
    endtask

    task automatic test_index_wrap;
        bit ok;
        gpio_write(16'd5, 8'hFF);
        gpio_write(16'd6, 8'hCD);
        gpio_write(16'd7, 8'hAB);
        gpio_write(16'd6, 8'h22);
        gpio_write(16'd7, 8'h11);
        gpio_write(16'd3, 8'h99);
        send_val(8'd255, ok);
        @(negedge clk);
        total++; if (m_axis_tdata !== rep(16'hABCD)) begin bad++; $display("FAIL wrap_255: got %h want %h", m_axis_tdata, rep(16'hABCD)); end
        send_val(8'd0, ok);
        @(negedge clk);
        total++; if (m_axis_tdata !== rep(16'h1122)) begin bad++; $display("FAIL wrap_0: got %h want %h", m_axis_tdata, rep(16'h1122)); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int first = -1;
        int second = -1;
        gpio_write(16'd8, 8'h12);
        val_in    = 8'd3;
        val_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (val_ready === 1'b1) begin
                if (n == 0) first = i;
                else if (n == 1) second = i;
                n++;
            end
            @(negedge clk);
        end
        val_valid = 1'b0;
        total++; if (n != 2)      begin bad++; $display("FAIL b2b_count: got %0d want 2", n); end
        total++; if (first != 0)  begin bad++; $display("FAIL b2b_first: got %0d want 0", first); end
        total++; if (second != 5) begin bad++; $display("FAIL b2b_second: got %0d want 5", second); end
    endtask

    task automatic test_enable_clear;
        bit ok;
        bit done = 1'b0;
        int codes = 0;
        int gaps = 0;
        int leaks = 0;
        gpio_write(16'd8, 8'h2F);
        send_val(8'd4, ok);
        gpio_write(16'd9, 8'h00);
        total++; if (m_axis_tdata !== rep(16'h5678)) begin bad++; $display("FAIL en_mid_pulse: got %h want %h", m_axis_tdata, rep(16'h5678)); end
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (busy !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if (m_axis_tdata === rep(16'h5678)) codes++;
            else if (m_axis_tdata === '0) gaps++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL en_finish: got %b want 1", done); end
        total++; if (codes != 8)    begin bad++; $display("FAIL en_codes: got %0d want 8", codes); end
        total++; if (gaps != 2)     begin bad++; $display("FAIL en_gaps: got %0d want 2", gaps); end
        val_in    = 8'd3;
        val_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (val_ready !== 1'b0 || busy !== 1'b0) leaks++;
        end
        val_valid = 1'b0;
        total++; if (leaks != 0) begin bad++; $display("FAIL en_blocked: got %0d accepting cycles want 0", leaks); end
        gpio_write(16'd9, 8'h01);
        total++; if (val_ready !== 1'b1) begin bad++; $display("FAIL en_restore: got %b want 1", val_ready); end
    endtask

    task automatic test_reset_mid_pulse;
        bit ok;
        gpio_write(16'd8, 8'h0F);
        send_val(8'd3, ok);
        repeat (2) @(negedge clk);
        total++; if (m_axis_tdata !== rep(16'h1234)) begin bad++; $display("FAIL rmp_pre: got %h want %h", m_axis_tdata, rep(16'h1234)); end
        rst = 1'b0;
        #1;
        total++; if (m_axis_tdata !== '0)    begin bad++; $display("FAIL rmp_tdata: got %h want 0", m_axis_tdata); end
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rmp_tvalid: got %b want 0", m_axis_tvalid); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rmp_busy: got %b want 0", busy); end
        total++; if (val_ready !== 1'b0)     begin bad++; $display("FAIL rmp_ready: got %b want 0", val_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        gpio_write(16'd9, 8'h01);
        send_val(8'd3, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmp_accept: got %b want 1", ok); end
        @(negedge clk);
        total++; if (m_axis_tdata !== rep(16'h1234)) begin bad++; $display("FAIL rmp_word: got %h want %h", m_axis_tdata, rep(16'h1234)); end
        @(negedge clk);
        total++; if (m_axis_tdata !== '0) begin bad++; $display("FAIL rmp_single: got %h want 0", m_axis_tdata); end
        total++; if (val_ready !== 1'b1)  begin bad++; $display("FAIL rmp_ready_after: got %b want 1", val_ready); end
    endtask

    initial begin
        test_reset;
        test_lut_load;
        test_timing;
        test_backpressure;
        test_pulse_zero;
        test_index_wrap;
        test_back_to_back;
        test_enable_clear;
        test_reset_mid_pulse;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
